// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequencer: playback states and
// default geometry of the pattern memory.
package pattern_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Playback state encoding; also reported on the debug state output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_ram.sv
// Simple dual-port synchronous pattern memory. One write port and one
// read port with read enable. A read and a write to the same address in
// the same cycle return the old word (read-first). The read register is
// asynchronously cleared so the displayed pattern is 0 out of reset; the
// storage array itself is not reset.
module pattern_ram
  import pattern_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; accepted every cycle regardless of playback state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; the old array contents are sampled, giving read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: steps through the pattern memory one word per
// prescaler tick, playing once or looping up to a latched final address.
//
// Control inputs are single-cycle pulses (start, stop) or levels (pause,
// loop). They are evaluated with priority stop > start > pause > tick.
// A tick only has effect in PLAY when no higher-priority control is active;
// that tick reads mem[rd_addr] into the output register, so pattern,
// done and wrap all change at the edge that samples clk_en=1.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] pattern,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PLAY  = PLAY;
  localparam logic [1:0] ST_PAUSE = PAUSE;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              tick_play;

  // Next-state, address counter and pulse generation in priority order.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    last_d    = last_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    tick_play = 1'b0;
    if (stop) begin
      state_d   = ST_IDLE;
      rd_addr_d = '0;
    end else if (start) begin
      state_d   = ST_PLAY;
      rd_addr_d = '0;
      last_d    = last_addr;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (clk_en) begin
            tick_play = 1'b1;
            if (rd_addr_q != last_q) begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
            end else if (loop) begin
              rd_addr_d = '0;
              wrap_d    = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              rd_addr_d = '0;
              done_d    = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_PLAY;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          // Unused encoding: fall back to a safe idle.
          state_d   = ST_IDLE;
          rd_addr_d = '0;
        end
      endcase
    end
  end

  // Control registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      last_q    <= last_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  // The RAM read register is the pattern output itself.
  pattern_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (tick_play),
    .rd_addr (rd_addr_q),
    .rd_data (pattern)
  );

  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: inputs are driven 1 time unit after
// each rising edge and outputs are checked there, away from the edge.
module tb_pattern_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              clk_en = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              wrap;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] seq [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  pattern_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop      (loop),
    .last_addr (last_addr),
    .pattern   (pattern),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] la, input logic lp);
    last_addr = la; loop = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_pattern", 32'(pattern), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Load and play once, one tick every 4 cycles
    for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), seq[i]);
    do_start(4'd3, 1'b0);
    chk("p1_busy_after_start", 32'(busy), 32'h1);
    chk("p1_state_play", 32'(dbg_state), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p1_pattern", 32'(pattern), 32'(seq[i]));
      chk("p1_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
      chk("p1_busy", 32'(busy), (i == 3) ? 32'h0 : 32'h1);
      step(); step(); step();
      chk("p1_done_gap", 32'(done), 32'h0);
    end
    tick();
    chk("p1_hold_after_done", 32'(pattern), 32'h08);
    chk("p1_rd_addr_idle", 32'(rd_addr), 32'h0);

    // Loop with back-to-back ticks
    do_start(4'd3, 1'b1);
    clk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("p2_pattern", 32'(pattern), 32'(seq[i % 4]));
      chk("p2_wrap", 32'(wrap), (i % 4 == 3) ? 32'h1 : 32'h0);
      chk("p2_done", 32'(done), 32'h0);
    end
    // Stop with the tick still high: tick loses to stop.
    do_stop();
    clk_en = 1'b0;
    chk("p2_stop_busy", 32'(busy), 32'h0);
    chk("p2_stop_hold", 32'(pattern), 32'h02);

    // Pause and stop
    do_start(4'd3, 1'b0);
    tick(); tick();
    chk("p3_before_pause", 32'(pattern), 32'h02);
    pause = 1'b1;
    clk_en = 1'b1;
    step();
    chk("p3_state_pause", 32'(dbg_state), 32'h2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p3_paused_pattern", 32'(pattern), 32'h02);
    end
    clk_en = 1'b0;
    chk("p3_paused_busy", 32'(busy), 32'h1);
    pause = 1'b0;
    step();
    chk("p3_resume_state", 32'(dbg_state), 32'h1);
    tick();
    chk("p3_resume_pattern", 32'(pattern), 32'h04);
    clk_en = 1'b1;
    do_stop();
    clk_en = 1'b0;
    chk("p3_stop_pattern", 32'(pattern), 32'h04);
    chk("p3_stop_rd_addr", 32'(rd_addr), 32'h0);
    chk("p3_stop_busy", 32'(busy), 32'h0);

    // last_addr = 0 with loop: every tick shows mem[0] and wraps
    do_start(4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p4_single_pattern", 32'(pattern), 32'h01);
      chk("p4_single_wrap", 32'(wrap), 32'h1);
      chk("p4_single_rd_addr", 32'(rd_addr), 32'h0);
    end
    step();
    chk("p4_wrap_drop", 32'(wrap), 32'h0);
    do_stop();

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("p4_start_stop_busy", 32'(busy), 32'h0);

    // Restart while playing at address 2
    do_start(4'd3, 1'b0);
    tick(); tick();
    chk("p4_at_addr2", 32'(rd_addr), 32'h2);
    do_start(4'd3, 1'b0);
    chk("p4_restart_rd_addr", 32'(rd_addr), 32'h0);
    tick();
    chk("p4_restart_pattern", 32'(pattern), 32'h01);

    // Write collision at address 1 on the tick that reads it
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("p5_collision_old", 32'(pattern), 32'h02);
    tick(); tick();
    chk("p5_done", 32'(done), 32'h1);
    do_start(4'd3, 1'b0);
    tick(); tick();
    chk("p5_new_word", 32'(pattern), 32'hAA);

    // Asynchronous reset between edges during PLAY
    chk("p6_busy_before", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("p6_async_pattern", 32'(pattern), 32'h0);
    chk("p6_async_busy", 32'(busy), 32'h0);
    chk("p6_async_rd_addr", 32'(rd_addr), 32'h0);
    #1 rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p6_no_start_pattern", 32'(pattern), 32'h0);
      chk("p6_no_start_busy", 32'(busy), 32'h0);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety timeout so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
